// File: rtl/uc_busca_pkg.sv
// Shared encodings and defaults for the paced linear-search control unit.
package uc_busca_pkg;

    localparam logic [3:0] ST_INICIAL    = 4'h0;
    localparam logic [3:0] ST_PREPARA    = 4'h1;
    localparam logic [3:0] ST_COMPARA    = 4'h2;
    localparam logic [3:0] ST_ESPERA     = 4'h3;
    localparam logic [3:0] ST_INCREMENTA = 4'h4;
    localparam logic [3:0] ST_CARREGA    = 4'h8;
    localparam logic [3:0] ST_ACHOU      = 4'hA;
    localparam logic [3:0] ST_ESGOTOU    = 4'hE;

    localparam int PASSO_W_DEF = 16;

    typedef enum logic [3:0] {
        INICIAL    = ST_INICIAL,
        PREPARA    = ST_PREPARA,
        COMPARA    = ST_COMPARA,
        ESPERA     = ST_ESPERA,
        INCREMENTA = ST_INCREMENTA,
        CARREGA    = ST_CARREGA,
        ACHOU      = ST_ACHOU,
        ESGOTOU    = ST_ESGOTOU
    } estado_t;

endpackage

// File: rtl/unidade_controle_busca_if.sv
// Control/status bundle between the search control unit and the counter datapath.
// Optional UC_PAUSA_EN adds the pausa input.
interface unidade_controle_busca_if;
    logic       iniciar;
    logic       carregar;
    logic       igual;
    logic       fim;
    logic       zera;
    logic       carrega;
    logic       conta;
    logic       pronto;
    logic       achou;
    logic [3:0] db_estado;
`ifdef UC_PAUSA_EN
    logic       pausa;
`endif

    modport master (
        input  iniciar, carregar, igual, fim,
`ifdef UC_PAUSA_EN
        input  pausa,
`endif
        output zera, carrega, conta, pronto, achou, db_estado
    );

    modport slave (
        output iniciar, carregar, igual, fim,
`ifdef UC_PAUSA_EN
        output pausa,
`endif
        input  zera, carrega, conta, pronto, achou, db_estado
    );
endinterface

// File: rtl/unidade_controle_busca_contador_passo.sv
// Pace counter: counts ESPERA cycles, done flags the last one (PASSO-1).
module contador_passo #(
    parameter int PASSO   = 1,
    parameter int PASSO_W = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);
    logic [PASSO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done = (cnt_q == PASSO_W'(PASSO - 1));
endmodule

// File: rtl/unidade_controle_busca.sv
// Moore control unit for a paced linear search over the 4-bit counter datapath.
// Optional UC_PAUSA_EN: pausa freezes the machine while it waits in ESPERA.
module unidade_controle_busca
    import uc_busca_pkg::*;
#(
    parameter int PASSO   = 1,
    parameter int PASSO_W = PASSO_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    unidade_controle_busca_if.master bus
);
    estado_t state_q, state_d;
    logic    zera_q, carrega_q, conta_q, pronto_q, achou_q;
    logic    zera_d, carrega_d, conta_d, pronto_d, achou_d;
    logic    passo_clr, passo_en, passo_done;
    logic    pausado;

`ifdef UC_PAUSA_EN
    assign pausado = bus.pausa;
`else
    assign pausado = 1'b0;
`endif

    contador_passo #(.PASSO(PASSO), .PASSO_W(PASSO_W)) u_passo (
        .clock (clock),
        .reset (reset),
        .clr   (passo_clr),
        .en    (passo_en),
        .done  (passo_done)
    );

    always_comb begin
        state_d   = state_q;
        passo_clr = 1'b0;
        passo_en  = 1'b0;
        case (state_q)
            INICIAL: begin
                if (bus.iniciar)       state_d = PREPARA;
                else if (bus.carregar) state_d = CARREGA;
            end
            CARREGA:    state_d = INICIAL;
            PREPARA:    state_d = COMPARA;
            COMPARA: begin
                if (bus.igual)    state_d = ACHOU;
                else if (bus.fim) state_d = ESGOTOU;
                else begin
                    state_d   = ESPERA;
                    passo_clr = 1'b1;
                end
            end
            ESPERA: begin
                if (!pausado) begin
                    if (passo_done) state_d  = INCREMENTA;
                    else            passo_en = 1'b1;
                end
            end
            INCREMENTA: state_d = COMPARA;
            ACHOU, ESGOTOU: begin
                if (bus.iniciar) state_d = PREPARA;
            end
            default:    state_d = INICIAL;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with state_q.
        zera_d    = (state_d == PREPARA);
        carrega_d = (state_d == CARREGA);
        conta_d   = (state_d == INCREMENTA);
        pronto_d  = (state_d == ACHOU) || (state_d == ESGOTOU);
        achou_d   = (state_d == ACHOU);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= INICIAL;
            zera_q    <= 1'b0;
            carrega_q <= 1'b0;
            conta_q   <= 1'b0;
            pronto_q  <= 1'b0;
            achou_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            zera_q    <= zera_d;
            carrega_q <= carrega_d;
            conta_q   <= conta_d;
            pronto_q  <= pronto_d;
            achou_q   <= achou_d;
        end
    end

    assign bus.zera      = zera_q;
    assign bus.carrega   = carrega_q;
    assign bus.conta     = conta_q;
    assign bus.pronto    = pronto_q;
    assign bus.achou     = achou_q;
    assign bus.db_estado = state_q;
endmodule
